// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (if_*) and load/store (ls_*).
// One transaction at a time; load/store has priority, bounded by a starvation guard for fetch.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SC_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                owner_r;      // 0 = fetch, 1 = load/store
    logic [ADDR_W-1:0]   addr_r;
    logic                we_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   wstrb_r;
    logic [SC_W-1:0]     starve_cnt_r;
    logic [TO_W-1:0]     tmo_cnt_r;

    logic                grant_if_s;
    logic                grant_ls_s;
    logic                resp_ok_s;
    logic                timeout_s;
    logic                resp_s;
    logic                err_s;
    logic [DATA_W-1:0]   rdata_s;

    // Arbitration: load/store wins unless fetch has been starved STARVE_MAX times in a row.
    always_comb begin
        grant_if_s = 1'b0;
        grant_ls_s = 1'b0;
        if ((state_r == ST_IDLE) && !rst) begin
            if (ls_req && !(if_req && (starve_cnt_r == SC_W'(STARVE_MAX)))) begin
                grant_ls_s = 1'b1;
            end else if (if_req) begin
                grant_if_s = 1'b1;
            end else begin
                grant_if_s = 1'b0;
            end
        end else begin
            grant_ls_s = 1'b0;
        end
    end

    // A real response in WAIT beats a timeout in the same cycle; mem_rvalid means nothing in ISSUE.
    always_comb begin
        resp_ok_s = (state_r == ST_WAIT) && mem_rvalid;
        timeout_s = (state_r != ST_IDLE) && (tmo_cnt_r == TO_W'(TIMEOUT)) && !resp_ok_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_if_s || grant_ls_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (timeout_s) begin
                    state_s = ST_IDLE;
                end else if (mem_gnt) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (resp_ok_s || timeout_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Outputs: everything forced low while reset is asserted, without waiting for a clock.
    always_comb begin
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        busy      = 1'b0;
        resp_s    = 1'b0;
        err_s     = 1'b0;
        rdata_s   = '0;
        if (!rst) begin
            case (state_r)
                ST_IDLE: begin
                    if_gnt = grant_if_s;
                    ls_gnt = grant_ls_s;
                end
                ST_ISSUE: begin
                    busy      = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = we_r;
                    mem_addr  = addr_r;
                    mem_wdata = wdata_r;
                    mem_wstrb = wstrb_r;
                    if (timeout_s) begin
                        resp_s = 1'b1;
                        err_s  = 1'b1;
                    end else begin
                        resp_s = 1'b0;
                    end
                end
                ST_WAIT: begin
                    busy = 1'b1;
                    if (resp_ok_s) begin
                        resp_s  = 1'b1;
                        rdata_s = mem_rdata;
                    end else if (timeout_s) begin
                        resp_s = 1'b1;
                        err_s  = 1'b1;
                    end else begin
                        resp_s = 1'b0;
                    end
                end
                default: busy = 1'b0;
            endcase
        end else begin
            busy = 1'b0;
        end
        if_rvalid = resp_s && !owner_r;
        if_err    = err_s && !owner_r;
        if_rdata  = owner_r ? '0 : rdata_s;
        ls_rvalid = resp_s && owner_r;
        ls_err    = err_s && owner_r;
        ls_rdata  = owner_r ? rdata_s : '0;
    end

    // Transaction capture on grant; fetch always reads with full byte enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r <= 1'b0;
            addr_r  <= '0;
            we_r    <= 1'b0;
            wdata_r <= '0;
            wstrb_r <= '0;
        end else if (grant_ls_s) begin
            owner_r <= 1'b1;
            addr_r  <= ls_addr;
            we_r    <= ls_we;
            wdata_r <= ls_wdata;
            wstrb_r <= ls_wstrb;
        end else if (grant_if_s) begin
            owner_r <= 1'b0;
            addr_r  <= if_addr;
            we_r    <= 1'b0;
            wdata_r <= '0;
            wstrb_r <= {STRB_W{1'b1}};
        end
    end

    // Starvation counter: counts ls grants that overtook a waiting fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (grant_ls_s && if_req) begin
            if (starve_cnt_r != SC_W'(STARVE_MAX)) begin
                starve_cnt_r <= starve_cnt_r + SC_W'(1);
            end
        end else if (grant_ls_s || grant_if_s) begin
            starve_cnt_r <= '0;
        end
    end

    // Timeout counter: cleared on grant, runs through ISSUE and WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (grant_ls_s || grant_if_s) begin
            tmo_cnt_r <= '0;
        end else if (state_r != ST_IDLE) begin
            tmo_cnt_r <= tmo_cnt_r + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after each rising edge, outputs sampled 3 ns after.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_we = 1'b0;
        ls_addr = 32'h0; ls_wdata = 32'h0; ls_wstrb = 4'h0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #3;
        checks++;
        if ({if_gnt, ls_gnt, mem_req, busy, if_rvalid, ls_rvalid, if_err, ls_err} !== 8'h00
            || if_rdata !== 32'h0 || ls_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b%b req=%b busy=%b rv=%b%b err=%b%b expected all 0",
                     if_gnt, ls_gnt, mem_req, busy, if_rvalid, ls_rvalid, if_err, ls_err);
        end
        tick();
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #2;
        checks++;
        if (busy !== 1'b0 || if_gnt !== 1'b0 || ls_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b if_gnt=%b ls_gnt=%b expected 0 0 0", busy, if_gnt, ls_gnt);
        end
    endtask

    task automatic test_single_fetch();
        tick(); if_req = 1'b1; if_addr = 32'h10; #2;
        checks++;
        if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_gnt: if_gnt=%b ls_gnt=%b busy=%b expected 1 0 0", if_gnt, ls_gnt, busy);
        end
        tick(); if_req = 1'b0; mem_gnt = 1'b1; #2;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || mem_wstrb !== 4'hF || busy !== 1'b1) begin
            errors++;
            $display("FAIL fetch_issue: req=%b addr=%h we=%b wstrb=%h busy=%b expected 1 00000010 0 f 1",
                     mem_req, mem_addr, mem_we, mem_wstrb, busy);
        end
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00A00093; #2;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h00A00093 || if_err !== 1'b0 || ls_rvalid !== 1'b0
            || ls_rdata !== 32'h0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp: if_rvalid=%b if_rdata=%h if_err=%b ls_rvalid=%b ls_rdata=%h req=%b expected 1 00a00093 0 0 0 0",
                     if_rvalid, if_rdata, if_err, ls_rvalid, ls_rdata, mem_req);
        end
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; #2;
        checks++;
        if (busy !== 1'b0 || if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: busy=%b if_rvalid=%b expected 0 0", busy, if_rvalid);
        end
    endtask

    task automatic test_contention();
        tick();
        if_req = 1'b1; if_addr = 32'h80;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hDEADBEEF; ls_wstrb = 4'hF;
        #2;
        checks++;
        if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL contention_gnt: ls_gnt=%b if_gnt=%b expected 1 0", ls_gnt, if_gnt);
        end
        tick(); ls_req = 1'b0; ls_we = 1'b0; mem_gnt = 1'b1; #2;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'hF || mem_addr !== 32'h200
            || mem_wdata !== 32'hDEADBEEF || if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL contention_issue: req=%b we=%b wstrb=%h addr=%h wdata=%h if_gnt=%b expected 1 1 f 00000200 deadbeef 0",
                     mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, if_gnt);
        end
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55; #2;
        checks++;
        if (ls_rvalid !== 1'b1 || ls_err !== 1'b0 || if_rvalid !== 1'b0 || if_gnt !== 1'b0 || if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL contention_resp: ls_rvalid=%b ls_err=%b if_rvalid=%b if_gnt=%b if_rdata=%h expected 1 0 0 0 0",
                     ls_rvalid, ls_err, if_rvalid, if_gnt, if_rdata);
        end
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; #2;
        checks++;
        if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
            errors++;
            $display("FAIL contention_fetch_gnt: if_gnt=%b ls_gnt=%b expected 1 0", if_gnt, ls_gnt);
        end
        tick(); if_req = 1'b0; mem_gnt = 1'b1; #2;
        checks++;
        if (mem_addr !== 32'h80 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL contention_fetch_issue: addr=%h we=%b wdata=%h expected 00000080 0 0", mem_addr, mem_we, mem_wdata);
        end
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #2;
        tick(); mem_rvalid = 1'b0;
    endtask

    task automatic test_starvation();
        int n_ls;
        bit got_if;
        tick();
        if_req = 1'b1; if_addr = 32'h400;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0;
        for (int round = 0; round < 2; round++) begin
            n_ls = 0;
            got_if = 1'b0;
            for (int cyc = 0; cyc < 40 && !got_if; cyc++) begin
                #2;
                if (ls_gnt === 1'b1) n_ls++;
                if (if_gnt === 1'b1) got_if = 1'b1;
                tick();
            end
            checks++;
            if (got_if !== 1'b1 || n_ls != 4) begin
                errors++;
                $display("FAIL starvation_round%0d: ls_grants=%0d fetch_granted=%b expected 4 1", round, n_ls, got_if);
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick(); tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; #2;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL starvation_drain: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_timeout();
        int early;
        tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500; mem_rdata = 32'h12345678; #2;
        checks++;
        if (ls_gnt !== 1'b1) begin
            errors++;
            $display("FAIL timeout_gnt: ls_gnt=%b expected 1", ls_gnt);
        end
        tick(); ls_req = 1'b0; mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        early = 0;
        for (int k = 2; k <= 255; k++) begin
            #2;
            if (ls_rvalid !== 1'b0 || ls_err !== 1'b0 || busy !== 1'b1) early++;
            tick();
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL timeout_early: premature_cycles=%0d expected 0", early);
        end
        #2;
        checks++;
        if (ls_rvalid !== 1'b1 || ls_err !== 1'b1 || ls_rdata !== 32'h0 || if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_resp: ls_rvalid=%b ls_err=%b ls_rdata=%h if_rvalid=%b expected 1 1 0 0",
                     ls_rvalid, ls_err, ls_rdata, if_rvalid);
        end
        tick(); mem_rvalid = 1'b1; #2;
        checks++;
        if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0 || ls_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_late_rvalid: ls_rvalid=%b if_rvalid=%b ls_err=%b busy=%b expected 0 0 0 0",
                     ls_rvalid, if_rvalid, ls_err, busy);
        end
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic test_stall();
        int bad;
        tick(); if_req = 1'b1; if_addr = 32'h44; #2;
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL stall_gnt: if_gnt=%b expected 1", if_gnt);
        end
        tick();
        if_req = 1'b0;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h600; ls_wdata = 32'h11223344; ls_wstrb = 4'h3;
        mem_gnt = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (mem_req !== 1'b1 || mem_addr !== 32'h44 || mem_we !== 1'b0 || ls_gnt !== 1'b0 || if_gnt !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: bad_cycles=%0d expected 0", bad);
        end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; #2;
        checks++;
        if (mem_req !== 1'b1 || if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: req=%b if_rvalid=%b expected 1 0", mem_req, if_rvalid);
        end
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001; #2;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hCAFE0001 || ls_gnt !== 1'b0) begin
            errors++;
            $display("FAIL stall_resp: if_rvalid=%b if_rdata=%h ls_gnt=%b expected 1 cafe0001 0", if_rvalid, if_rdata, ls_gnt);
        end
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; #2;
        checks++;
        if (ls_gnt !== 1'b1) begin
            errors++;
            $display("FAIL stall_next_gnt: ls_gnt=%b expected 1", ls_gnt);
        end
        tick(); ls_req = 1'b0; mem_gnt = 1'b1; #2;
        checks++;
        if (mem_we !== 1'b1 || mem_wstrb !== 4'h3 || mem_wdata !== 32'h11223344 || mem_addr !== 32'h600) begin
            errors++;
            $display("FAIL stall_store_issue: we=%b wstrb=%h wdata=%h addr=%h expected 1 3 11223344 00000600",
                     mem_we, mem_wstrb, mem_wdata, mem_addr);
        end
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #2;
        checks++;
        if (ls_rvalid !== 1'b1 || ls_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_store_resp: ls_rvalid=%b ls_err=%b expected 1 0", ls_rvalid, ls_err);
        end
        tick(); mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick(); if_req = 1'b1; if_addr = 32'h90; #2;
        tick(); if_req = 1'b0; mem_gnt = 1'b1; #2;
        tick(); mem_gnt = 1'b0; #2;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: busy=%b expected 1", busy);
        end
        rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77; #1;
        checks++;
        if ({busy, mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 6'b000000 || if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: busy=%b req=%b gnt=%b%b rv=%b%b if_rdata=%h expected all 0",
                     busy, mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_rdata);
        end
        tick(); #2;
        checks++;
        if ({busy, mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 6'b000000) begin
            errors++;
            $display("FAIL rstmid_held: busy=%b req=%b gnt=%b%b rv=%b%b expected all 0",
                     busy, mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid);
        end
        ls_req = 1'b0; rst = 1'b0; #1;
        checks++;
        if (if_gnt !== 1'b1 || if_rvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_regrant: if_gnt=%b if_rvalid=%b busy=%b expected 1 0 0", if_gnt, if_rvalid, busy);
        end
        tick(); if_req = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b1; #2;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h90) begin
            errors++;
            $display("FAIL rstmid_issue: req=%b addr=%h expected 1 00000090", mem_req, mem_addr);
        end
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hABCD0123; #2;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hABCD0123) begin
            errors++;
            $display("FAIL rstmid_resp: if_rvalid=%b if_rdata=%h expected 1 abcd0123", if_rvalid, if_rdata);
        end
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_timeout();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
